// File: rtl/camac_tag_buffer_if.sv
// CAMAC dataway bundle for the tag buffer: F/A command lines, strobes, station
// selects and the active-low response lines returned by the module.
interface camac_tag_buffer_if;
    logic [4:0]  F;
    logic [3:0]  A;
    logic        S1;
    logic        S2;
    logic        N;
    logic        B;
    logic        C;
    logic        Z;
    logic        I;
    logic [15:0] CRDATA;
    logic        OE;
    logic        X;
    logic        Q;
    logic        L;

    modport slave (
        input  F, A, S1, S2, N, B, C, Z, I,
        output CRDATA, OE, X, Q, L
    );

    modport master (
        output F, A, S1, S2, N, B, C, Z, I,
        input  CRDATA, OE, X, Q, L
    );
endinterface

// File: rtl/camac_tag_buffer.sv
// Event-tag FIFO read out over a CAMAC dataway: asynchronous triggers capture
// {LOCK, ENC, SNC}; CAMAC functions read, pop, clear and gate the LAM.
module camac_tag_buffer #(
    parameter int ENC_W = 14,
    parameter int SNC_W = 10,
    parameter int DEPTH = 16
) (
    input  logic             SYSCLK,
    input  logic             RSTN,
    input  logic [ENC_W-1:0] ENC,
    input  logic [SNC_W-1:0] SNC,
    input  logic             LOCK,
    input  logic             TRIG,
    camac_tag_buffer_if.slave dw
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = 1 + ENC_W + SNC_W;

    // Synchroniser lanes, bit order {TRIG, S1, S2, N}
    logic [3:0] meta_q, meta_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] sync_q, sync_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] rise;

    logic nb_q, nb_d;
    logic cmd_active;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             lam_en_q, lam_en_d;
    logic             x_q, x_d;
    logic             q_q, q_d;
    logic             oe_q, oe_d;
    logic             l_q, l_d;

    logic f0a0, f0a1, f0a2, f2a0, f8a0, f9a0, f24a0, f26a0;
    logic f0_any, valid_fn;
    logic empty, full;
    logic strobe, push_req, push, pop, clr_dw, clear, lam_pending;
    logic [TAG_W-1:0] head_tag;
    logic [15:0]      rd_word;

    always_comb begin
        meta_d  = {TRIG, dw.S1, dw.S2, dw.N};
        sync2_d = meta_q;
        sync_d  = sync2_q;
        prev_d  = sync_q;
        rise    = sync_q & ~prev_q;
    end

    // A command is live only after N and B have been seen together twice in a row
    always_comb begin
        nb_d       = sync_q[0] & dw.B;
        cmd_active = sync_q[0] & dw.B & nb_q;
    end

    always_comb begin
        f0a0     = (dw.F == 5'd0)  && (dw.A == 4'd0);
        f0a1     = (dw.F == 5'd0)  && (dw.A == 4'd1);
        f0a2     = (dw.F == 5'd0)  && (dw.A == 4'd2);
        f2a0     = (dw.F == 5'd2)  && (dw.A == 4'd0);
        f8a0     = (dw.F == 5'd8)  && (dw.A == 4'd0);
        f9a0     = (dw.F == 5'd9)  && (dw.A == 4'd0);
        f24a0    = (dw.F == 5'd24) && (dw.A == 4'd0);
        f26a0    = (dw.F == 5'd26) && (dw.A == 4'd0);
        f0_any   = f0a0 | f0a1 | f0a2;
        valid_fn = f0_any | f2a0 | f8a0 | f9a0 | f24a0 | f26a0;
    end

    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(DEPTH));
        head_tag    = mem_q[rd_ptr_q];
        strobe      = rise[2] & cmd_active;
        push_req    = rise[3] & ~dw.I;
        pop         = strobe & f2a0 & ~empty;
        push        = push_req & (~full | pop);
        clr_dw      = dw.B & sync_q[1] & (dw.C | dw.Z);
        clear       = clr_dw | (strobe & f9a0);
        lam_pending = lam_en_q & ~empty & ~dw.I;
    end

    // Read word selection; an empty FIFO reads as zero on the tag addresses
    always_comb begin
        rd_word = '0;
        if ((f0a0 || f2a0) && !empty) begin
            rd_word[15]        = head_tag[TAG_W-1];
            rd_word[ENC_W-1:0] = head_tag[SNC_W +: ENC_W];
        end else if (f0a1 && !empty) begin
            rd_word[15]        = head_tag[TAG_W-1];
            rd_word[SNC_W-1:0] = head_tag[SNC_W-1:0];
        end else if (f0a2) begin
            rd_word[15]        = ovf_q;
            rd_word[CNT_W-1:0] = count_q;
        end
    end

    // Clear outranks push and pop; a full FIFO still accepts a push paired with a pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {LOCK, ENC, SNC};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push_req && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        lam_en_d = lam_en_q;
        if (dw.Z && dw.B && sync_q[1]) begin
            lam_en_d = 1'b0;
        end else if (strobe && f24a0) begin
            lam_en_d = 1'b0;
        end else if (strobe && f26a0) begin
            lam_en_d = 1'b1;
        end
    end

    always_comb begin
        x_d  = 1'b1;
        q_d  = 1'b1;
        oe_d = 1'b1;
        l_d  = ~lam_pending;
        if (cmd_active) begin
            x_d  = ~valid_fn;
            oe_d = ~(f0_any | f2a0);
            q_d  = ~(f0_any | f9a0 | f24a0 | f26a0 |
                     (f2a0 & ~empty) | (f8a0 & lam_pending));
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RSTN) begin
            meta_q   <= '0;
            sync2_q  <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            nb_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            lam_en_q <= 1'b0;
            x_q      <= 1'b1;
            q_q      <= 1'b1;
            oe_q     <= 1'b1;
            l_q      <= 1'b1;
        end else begin
            meta_q   <= meta_d;
            sync2_q  <= sync2_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            nb_q     <= nb_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            lam_en_q <= lam_en_d;
            x_q      <= x_d;
            q_q      <= q_d;
            oe_q     <= oe_d;
            l_q      <= l_d;
        end
    end

    // Tag storage needs no reset; the pointers and count define what is valid
    always_ff @(posedge SYSCLK) begin
        mem_q <= mem_d;
    end

    assign dw.CRDATA = ~rd_word;
    assign dw.X      = x_q;
    assign dw.Q      = q_q;
    assign dw.OE     = oe_q;
    assign dw.L      = l_q;
endmodule

// File: tb/tb_camac_tag_buffer.sv
// Randomised and directed bench for camac_tag_buffer against a queue-based
// model of the tag FIFO, overflow flag and LAM enable.
module tb_camac_tag_buffer;
    localparam int ENC_W = 14;
    localparam int SNC_W = 10;
    localparam int DEPTH = 4;

    logic             SYSCLK = 1'b0;
    logic             RSTN   = 1'b0;
    logic [ENC_W-1:0] ENC    = '0;
    logic [SNC_W-1:0] SNC    = '0;
    logic             LOCK   = 1'b0;
    logic             TRIG   = 1'b0;

    camac_tag_buffer_if dw();

    camac_tag_buffer #(.ENC_W(ENC_W), .SNC_W(SNC_W), .DEPTH(DEPTH)) dut (
        .SYSCLK (SYSCLK),
        .RSTN   (RSTN),
        .ENC    (ENC),
        .SNC    (SNC),
        .LOCK   (LOCK),
        .TRIG   (TRIG),
        .dw     (dw.slave)
    );

    always #10 SYSCLK = ~SYSCLK;

    logic [24:0] mq[$];
    bit          m_ovf  = 1'b0;
    bit          m_lam  = 1'b0;
    bit          cmd_on = 1'b0;
    int          total  = 0;
    int          bad    = 0;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_valid(input int f, input int a);
        return (f == 0 && a <= 2) ||
               (a == 0 && (f == 2 || f == 8 || f == 9 || f == 24 || f == 26));
    endfunction

    function automatic bit lam_pending();
        return m_lam && mq.size() > 0 && dw.I == 1'b0;
    endfunction

    function automatic logic [15:0] exp_word(input int f, input int a);
        logic [15:0] w;
        logic [24:0] h;
        w = 16'h0000;
        if (mq.size() > 0) h = mq[0];
        else h = '0;
        if ((f == 0 || f == 2) && a == 0 && mq.size() > 0)
            w = {h[24], 1'b0, h[23:10]};
        else if (f == 0 && a == 1 && mq.size() > 0)
            w = {h[24], 5'b0, h[9:0]};
        else if (f == 0 && a == 2)
            w = {m_ovf, 12'b0, 3'(mq.size())};
        return w;
    endfunction

    function automatic logic [15:0] exp_q(input int f, input int a);
        if (!cmd_on) return 16'd1;
        if (f == 0 && a <= 2) return 16'd0;
        if (a == 0 && (f == 9 || f == 24 || f == 26)) return 16'd0;
        if (f == 2 && a == 0) return (mq.size() == 0) ? 16'd1 : 16'd0;
        if (f == 8 && a == 0) return lam_pending() ? 16'd0 : 16'd1;
        return 16'd1;
    endfunction

    task automatic check_state(input string tag);
        int f, a;
        f = int'(dw.F);
        a = int'(dw.A);
        check_output({tag, "/crd"}, dw.CRDATA, ~exp_word(f, a));
        check_output({tag, "/x"}, {15'b0, dw.X}, (cmd_on && is_valid(f, a)) ? 16'd0 : 16'd1);
        check_output({tag, "/oe"}, {15'b0, dw.OE},
                     (cmd_on && is_valid(f, a) && (f == 0 || f == 2)) ? 16'd0 : 16'd1);
        check_output({tag, "/q"}, {15'b0, dw.Q}, exp_q(f, a));
        check_output({tag, "/l"}, {15'b0, dw.L}, lam_pending() ? 16'd0 : 16'd1);
    endtask

    task automatic model_push(input logic [24:0] t);
        if (mq.size() < DEPTH) mq.push_back(t);
        else m_ovf = 1'b1;
    endtask

    task automatic apply_trigger(input logic lock, input logic [13:0] enc,
                                 input logic [9:0] snc, input logic inh);
        LOCK = lock; ENC = enc; SNC = snc; dw.I = inh;
        TRIG = 1'b1;
        wait_cycles(5);
        if (!inh) model_push({lock, enc, snc});
        TRIG = 1'b0;
        wait_cycles(5);
        dw.I = 1'b0;
        wait_cycles(2);
    endtask

    task automatic apply_command(input int f, input int a, input bit stb, input string tag);
        dw.F = 5'(f); dw.A = 4'(a);
        dw.N = 1'b1; dw.B = 1'b1;
        wait_cycles(7);
        cmd_on = 1'b1;
        check_state(tag);
        if (stb) begin
            dw.S1 = 1'b1;
            wait_cycles(5);
            if (a == 0) begin
                if (f == 2 && mq.size() > 0) void'(mq.pop_front());
                if (f == 9) begin mq.delete(); m_ovf = 1'b0; end
                if (f == 24) m_lam = 1'b0;
                if (f == 26) m_lam = 1'b1;
            end
            dw.S1 = 1'b0;
            wait_cycles(4);
            check_state({tag, "+stb"});
        end
        dw.N = 1'b0; dw.B = 1'b0;
        wait_cycles(6);
        cmd_on = 1'b0;
    endtask

    task automatic apply_clear(input bit z, input string tag);
        dw.B = 1'b1; dw.C = !z; dw.Z = z; dw.S2 = 1'b1;
        wait_cycles(5);
        mq.delete(); m_ovf = 1'b0;
        if (z) m_lam = 1'b0;
        dw.S2 = 1'b0;
        wait_cycles(4);
        dw.C = 1'b0; dw.Z = 1'b0; dw.B = 1'b0;
        wait_cycles(1);
        check_state(tag);
    endtask

    // Trigger and F2A0 strobe launched together so both edges land in one cycle
    task automatic apply_push_pop(input logic [24:0] t, input string tag);
        dw.F = 5'd2; dw.A = 4'd0;
        dw.N = 1'b1; dw.B = 1'b1;
        LOCK = t[24]; ENC = t[23:10]; SNC = t[9:0];
        wait_cycles(7);
        cmd_on = 1'b1;
        check_state(tag);
        TRIG = 1'b1; dw.S1 = 1'b1;
        wait_cycles(5);
        if (mq.size() > 0) void'(mq.pop_front());
        model_push(t);
        TRIG = 1'b0; dw.S1 = 1'b0;
        wait_cycles(4);
        check_state({tag, "+pp"});
        dw.N = 1'b0; dw.B = 1'b0;
        wait_cycles(6);
        cmd_on = 1'b0;
    endtask

    task automatic set_inhibit(input logic v, input string tag);
        dw.I = v;
        wait_cycles(2);
        check_state(tag);
    endtask

    function automatic logic [24:0] rnd_tag();
        return {1'($urandom_range(0, 1)), 14'($urandom_range(0, 16383)), 10'($urandom_range(0, 1023))};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fl[8];
        int al[8];
        logic [24:0] t;
        fl = '{0, 0, 0, 2, 8, 9, 24, 26};
        al = '{0, 1, 2, 0, 0, 0, 0, 0};
        dw.F = '0; dw.A = '0; dw.S1 = 0; dw.S2 = 0; dw.N = 0;
        dw.B = 0; dw.C = 0; dw.Z = 0; dw.I = 0;
        wait_cycles(3);
        check_state("reset");
        RSTN = 1'b1;
        wait_cycles(2);

        // Three tags in, then count read and ordered pops
        for (int k = 0; k < 3; k++) apply_trigger(1'b0, 14'(5 + k), 10'(k), 1'b0);
        apply_command(0, 2, 0, "cnt3");
        for (int k = 0; k < 3; k++) apply_command(2, 0, 1, $sformatf("pop%0d", k));
        apply_command(2, 0, 1, "pop_empty");

        // Overflow on a depth-4 FIFO, drain in order, then F9 clear
        for (int k = 0; k < 5; k++) begin
            t = rnd_tag();
            apply_trigger(t[24], t[23:10], t[9:0], 1'b0);
        end
        apply_command(0, 2, 0, "ovf");
        apply_command(0, 1, 0, "snc_head");
        apply_command(2, 0, 1, "drain0");
        apply_command(9, 0, 1, "f9clr");
        apply_command(0, 2, 0, "after_clr");

        // LAM path
        apply_command(26, 0, 1, "lam_on");
        apply_trigger(1'b1, 14'd100, 10'd3, 1'b0);
        check_state("lam_pend");
        set_inhibit(1'b1, "inh1");
        set_inhibit(1'b0, "inh0");
        apply_command(8, 0, 0, "f8_pend");
        apply_command(2, 0, 1, "lam_pop");
        apply_command(8, 0, 0, "f8_idle");

        // Push and pop in the same cycle at count 2, then at full
        apply_trigger(1'b0, 14'd11, 10'd1, 1'b0);
        apply_trigger(1'b0, 14'd12, 10'd2, 1'b0);
        apply_push_pop({1'b0, 14'd13, 10'd3}, "pp2");
        apply_command(0, 2, 0, "pp2_cnt");
        apply_trigger(1'b0, 14'd14, 10'd4, 1'b0);
        apply_trigger(1'b0, 14'd15, 10'd5, 1'b0);
        apply_push_pop({1'b1, 14'd16, 10'd6}, "ppfull");
        for (int k = 0; k < 4; k++) apply_command(2, 0, 1, $sformatf("ppord%0d", k));

        // Z clear with LAM enabled, then an unmapped function
        apply_command(26, 0, 1, "lam_on2");
        for (int k = 0; k < 3; k++) apply_trigger(1'b0, 14'(20 + k), 10'(k), 1'b0);
        check_state("pre_z");
        apply_clear(1'b1, "zclr");
        apply_trigger(1'b0, 14'd30, 10'd0, 1'b0);
        check_state("lam_off");
        apply_command(5, 7, 0, "f5a7");
        apply_clear(1'b0, "cclr");

        // Reset in the middle of an F0A0 command
        apply_trigger(1'b0, 14'd40, 10'd0, 1'b0);
        apply_trigger(1'b0, 14'd41, 10'd1, 1'b0);
        dw.F = 5'd0; dw.A = 4'd0; dw.N = 1'b1; dw.B = 1'b1;
        wait_cycles(7);
        cmd_on = 1'b1;
        check_state("pre_rst");
        RSTN = 1'b0;
        wait_cycles(1);
        cmd_on = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_lam = 1'b0;
        check_state("mid_rst");
        RSTN = 1'b1;
        dw.N = 1'b0; dw.B = 1'b0;
        wait_cycles(6);
        apply_command(0, 2, 0, "post_rst");

        // Randomised mix of triggers, commands, clears and paired push/pop
        for (int k = 0; k < 70; k++) begin
            int sel, idx, f, a;
            sel = $urandom_range(0, 9);
            t = rnd_tag();
            if (sel <= 2) begin
                apply_trigger(t[24], t[23:10], t[9:0], 1'($urandom_range(0, 4) == 0));
            end else if (sel <= 6) begin
                idx = $urandom_range(0, 7);
                f = fl[idx]; a = al[idx];
                if ($urandom_range(0, 4) == 0) begin
                    f = $urandom_range(0, 31);
                    a = $urandom_range(0, 15);
                end
                apply_command(f, a, $urandom_range(0, 9) < 6, $sformatf("rnd%0d_f%0da%0d", k, f, a));
            end else if (sel == 7) begin
                apply_push_pop(t, $sformatf("rnd%0d_pp", k));
            end else if (sel == 8) begin
                apply_clear(1'($urandom_range(0, 1)), $sformatf("rnd%0d_clr", k));
            end else begin
                apply_command(0, 2, 0, $sformatf("rnd%0d_cnt", k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
